// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the program-run checker: FSM encoding and default parameters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_IDX_W          = 5;
    localparam int DEF_STABLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    // Bits needed to hold values 0..maxval.
    function automatic int cnt_w(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/prog_run_checker_if.sv
// Debug-side bus of the run checker: register-file read port and expected-table write port.
// Latency: rf_rdata is combinational on rf_raddr; table writes land on the next clk edge.
// Backpressure: none; table writes outside IDLE/DONE are silently dropped by the checker.
//   master : host/CPU side (drives rf_rdata and exp_*, observes rf_raddr)
//   slave  : checker side
interface prog_run_checker_if
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
);
    logic [IDX_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [DATA_W-1:0] exp_value;
    logic              exp_care;

    modport master (
        input  rf_raddr,
        output rf_rdata, exp_we, exp_idx, exp_value, exp_care
    );

    modport slave (
        output rf_raddr,
        input  rf_rdata, exp_we, exp_idx, exp_value, exp_care
    );
endinterface

// File: rtl/prog_run_checker_exp_table.sv
// Expected-value table: NUM_REGS entries of {care, value}.
// Latency: write takes effect on the next clk edge; read is combinational.
// Backpressure: none; writes to indices >= NUM_REGS are dropped.
//   clk/rst        : clock, synchronous active-high reset (clears care bits only)
//   we/widx/wvalue/wcare : write port
//   ridx/rvalue/rcare    : asynchronous read port
module exp_table
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wvalue,
    input  logic              wcare,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rvalue,
    output logic              rcare
);
    localparam logic [IDX_W:0] NUM_ENTRIES = (IDX_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] value_mem [NUM_REGS];
    logic [NUM_REGS-1:0] care_bits;
    logic wr_ok;

    assign wr_ok = we && ({1'b0, widx} < NUM_ENTRIES);

    // Only the care bits are reset: an entry whose care bit is 0 never
    // influences a verdict, so stale values are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            care_bits <= '0;
        end else if (wr_ok) begin
            care_bits[widx] <= wcare;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            value_mem[widx] <= wvalue;
        end
    end

    assign rvalue = value_mem[ridx];
    assign rcare  = care_bits[ridx];

endmodule

// File: rtl/prog_run_checker.sv
// Watches a CPU pc for a halt (or timeout), then scans the register file against an expected table.
// Latency: halt seen after STABLE_CYCLES equal pc samples; verdict (done pulse) NUM_REGS cycles later.
// Backpressure: none; start while busy and table writes while busy are ignored.
//   clk, rst         : clock, synchronous active-high reset
//   start, pc        : begin monitoring (pulse), CPU program counter
//   dbg (slave)      : rf_raddr/rf_rdata register-file debug read, exp_* table write
//   busy, done, pass, timed_out, mismatch_cnt, first_bad_idx, first_bad_data : status/verdict
module prog_run_checker
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int IDX_W          = DEF_IDX_W,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,   // expected >= 2
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    prog_run_checker_if.slave dbg,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [IDX_W:0]    mismatch_cnt,
    output logic [IDX_W-1:0]  first_bad_idx,
    output logic [DATA_W-1:0] first_bad_data
);
    localparam int SC_W = cnt_w(STABLE_CYCLES);
    localparam int TO_W = cnt_w(TIMEOUT_CYCLES);

    // stable_cnt holds the number of equal-pc comparisons seen so far; the
    // halt fires on the comparison that would bring it to STABLE_CYCLES-1.
    localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W:0]   CNT_MAX     = '1;

    state_t            state;
    logic [ADDR_W-1:0] prev_pc;
    logic [SC_W-1:0]   stable_cnt;
    logic [TO_W-1:0]   cyc_cnt;
    logic [IDX_W-1:0]  scan_idx;

    logic              tbl_we;
    logic [DATA_W-1:0] exp_value_rd;
    logic              exp_care_rd;
    logic              pc_same;
    logic              halt_hit;
    logic              timeout_hit;
    logic              reg_bad;
    logic [IDX_W:0]    cnt_next;

    // The table is frozen while a run/scan is in flight so the verdict always
    // reflects the table as it stood at start.
    assign tbl_we = dbg.exp_we && ((state == ST_IDLE) || (state == ST_DONE));

    exp_table #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_exp_table (
        .clk    (clk),
        .rst    (rst),
        .we     (tbl_we),
        .widx   (dbg.exp_idx),
        .wvalue (dbg.exp_value),
        .wcare  (dbg.exp_care),
        .ridx   (scan_idx),
        .rvalue (exp_value_rd),
        .rcare  (exp_care_rd)
    );

    // scan_idx is forced to 0 whenever the FSM leaves SCAN, so it doubles as
    // the externally visible read address.
    assign dbg.rf_raddr = scan_idx;

    assign pc_same     = (pc == prev_pc);
    assign halt_hit    = pc_same && (stable_cnt == STABLE_LAST);
    assign timeout_hit = (cyc_cnt == TO_LAST);
    assign reg_bad     = exp_care_rd && (dbg.rf_rdata != exp_value_rd);
    assign cnt_next    = (reg_bad && (mismatch_cnt != CNT_MAX)) ? mismatch_cnt + 1'b1 : mismatch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            prev_pc        <= '0;
            stable_cnt     <= '0;
            cyc_cnt        <= '0;
            scan_idx       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            mismatch_cnt   <= '0;
            first_bad_idx  <= '0;
            first_bad_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // The pc seen with start is the first sample of the run.
                        state          <= ST_RUN;
                        busy           <= 1'b1;
                        prev_pc        <= pc;
                        stable_cnt     <= '0;
                        cyc_cnt        <= '0;
                        pass           <= 1'b0;
                        timed_out      <= 1'b0;
                        mismatch_cnt   <= '0;
                        first_bad_idx  <= '0;
                        first_bad_data <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    prev_pc    <= pc;
                    cyc_cnt    <= cyc_cnt + 1'b1;
                    stable_cnt <= pc_same ? stable_cnt + 1'b1 : '0;
                    if (halt_hit || timeout_hit) begin
                        state     <= ST_SCAN;
                        scan_idx  <= '0;
                        // A halt on the timeout cycle still counts as a clean halt.
                        timed_out <= !halt_hit;
                    end
                end

                ST_SCAN: begin
                    mismatch_cnt <= cnt_next;
                    if (reg_bad && (mismatch_cnt == '0)) begin
                        first_bad_idx  <= scan_idx;
                        first_bad_data <= dbg.rf_rdata;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (cnt_next == '0) && !timed_out;
                        scan_idx <= '0;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_run_checker.sv
// Directed + randomized bench for prog_run_checker with a trace-level reference model.
// Latency: model predicts the halt cycle from the pc trace and the done cycle NUM_REGS later.
// Backpressure: n/a.
module tb_prog_run_checker;
    import mips_dbg_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NR    = 32;
    localparam int IW    = 5;
    localparam int SC    = 4;
    localparam int TO    = 100;
    localparam int TRMAX = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pc;
    logic          busy, done, pass, timed_out;
    logic [IW:0]   mismatch_cnt;
    logic [IW-1:0] first_bad_idx;
    logic [DW-1:0] first_bad_data;

    prog_run_checker_if #(.DATA_W(DW), .IDX_W(IW)) ifc ();

    prog_run_checker #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .IDX_W(IW),
        .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .dbg            (ifc),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timed_out      (timed_out),
        .mismatch_cnt   (mismatch_cnt),
        .first_bad_idx  (first_bad_idx),
        .first_bad_data (first_bad_data)
    );

    always #5 clk = ~clk;

    // Register-file model seen by the debug read port.
    logic [DW-1:0] regs [NR];
    assign ifc.rf_rdata = regs[ifc.rf_raddr];

    // Model of the expected table as written by the bench.
    logic [DW-1:0] m_val  [NR];
    logic          m_care [NR];

    logic [AW-1:0] trace [TRMAX];
    int            tlen;

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // pc sample k of a run (sample 0 is taken with start); the trace's last
    // value is held forever afterwards.
    function automatic logic [AW-1:0] tr(input int k);
        return (k < tlen) ? trace[k] : trace[tlen-1];
    endfunction

    // Run cycle at which RUN ends: first k with SC equal samples ending at k,
    // otherwise TO (timeout). A halt at k == TO wins over the timeout.
    function automatic int model_end(output bit t_out);
        bit eq;
        t_out = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            eq = (k >= SC - 1);
            for (int j = k - SC + 1; j < k; j++) begin
                if (eq && (tr(j) != tr(k))) eq = 1'b0;
            end
            if (eq) return k;
            if (k == TO) begin
                t_out = 1'b1;
                return k;
            end
        end
        return TO;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_exp(input int idx, input logic [DW-1:0] val, input logic care);
        ifc.exp_we    = 1'b1;
        ifc.exp_idx   = IW'(idx);
        ifc.exp_value = val;
        ifc.exp_care  = care;
        step();
        ifc.exp_we = 1'b0;
        m_val[idx]  = val;
        m_care[idx] = care;
    endtask

    task automatic gen_trace(input int segs);
        logic [AW-1:0] p;
        int n;
        p = $urandom & 32'h0000_FFFC;
        n = 0;
        for (int s = 0; s < segs; s++) begin
            int h;
            h = $urandom_range(1, 3);
            for (int j = 0; j < h; j++) begin
                trace[n] = p;
                n++;
            end
            p = p + 32'd4;
        end
        trace[n] = p;
        tlen = n + 1;
    endtask

    // Start a run and follow it to done (or to a reset injected rst_at cycles
    // into SCAN). we_at / start_at inject a table write / start at that RUN edge.
    task automatic run_case(input string tag, input int we_at, input int start_at, input int rst_at);
        int k, bad, fidx;
        bit t_out, got, exp_pass;
        logic [DW-1:0] fdat;
        k = model_end(t_out);
        bad = 0; fidx = 0; fdat = '0;
        for (int i = 0; i < NR; i++) begin
            if (m_care[i] && (regs[i] !== m_val[i])) begin
                if (bad == 0) begin
                    fidx = i;
                    fdat = regs[i];
                end
                bad++;
            end
        end
        exp_pass = (bad == 0) && !t_out;

        pc = tr(0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ".busy_on_start"}, 64'(busy), 64'd1);

        got = 1'b0;
        for (int e = 1; e <= k + NR + 4; e++) begin
            pc = tr(e);
            if (e == we_at) begin
                ifc.exp_we    = 1'b1;
                ifc.exp_idx   = IW'(2);
                ifc.exp_value = 32'hDEAD_0099;
                ifc.exp_care  = 1'b1;
            end
            if (e == start_at) start = 1'b1;
            step();
            ifc.exp_we = 1'b0;
            start = 1'b0;
            chk({tag, ".raddr"}, 64'(ifc.rf_raddr),
                (e >= k && e < k + NR) ? 64'(e - k) : 64'd0);
            if (rst_at >= 0 && e == k + rst_at) begin
                chk({tag, ".no_done_before_rst"}, 64'(done), 64'd0);
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk({tag, ".rst_outs"},
                    {busy, done, pass, timed_out, mismatch_cnt, first_bad_idx, first_bad_data}, 64'd0);
                chk({tag, ".rst_raddr"}, 64'(ifc.rf_raddr), 64'd0);
                for (int i = 0; i < NR; i++) m_care[i] = 1'b0;
                return;
            end
            if (done) begin
                got = 1'b1;
                chk({tag, ".done_cycle"}, 64'(e), 64'(k + NR));
                chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
                chk({tag, ".timed_out"}, 64'(timed_out), 64'(t_out));
                chk({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'(bad));
                chk({tag, ".first_bad_idx"}, 64'(first_bad_idx), 64'(fidx));
                chk({tag, ".first_bad_data"}, 64'(first_bad_data), 64'(fdat));
                chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
                break;
            end
        end
        if (!got) chk({tag, ".done_seen"}, 64'd0, 64'd1);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc = '0;
        ifc.exp_we = 1'b0; ifc.exp_idx = '0; ifc.exp_value = '0; ifc.exp_care = 1'b0;
        randomize_regs();
        for (int i = 0; i < NR; i++) begin
            m_val[i]  = '0;
            m_care[i] = 1'b0;
        end
        repeat (3) step();
        chk("reset.outs", {busy, done, pass, timed_out, mismatch_cnt, first_bad_idx, first_bad_data}, 64'd0);
        chk("reset.raddr", 64'(ifc.rf_raddr), 64'd0);
        rst = 1'b0;
        step();
        chk("idle.busy", 64'(busy), 64'd0);

        // Factorial: $v0 = 0x78, program ends in a j-self loop at 0x40.
        randomize_regs();
        regs[2] = 32'h78;
        write_exp(2, 32'h78, 1'b1);
        for (int i = 0; i <= 16; i++) trace[i] = 32'(4 * i);
        tlen = 17;
        run_case("fact", 3, -1, -1);
        step();
        chk("fact.done_pulse_len", 64'(done), 64'd0);
        chk("fact.pass_held", 64'(pass), 64'd1);

        // Same program, wrong expectation.
        write_exp(2, 32'h77, 1'b1);
        run_case("fact_bad", -1, -1, -1);

        // Timeout with a start pulse mid-RUN that must not restart the counters.
        for (int i = 0; i < TRMAX; i++) trace[i] = 32'h1000 + 32'(4 * i);
        tlen = TRMAX;
        run_case("timeout", -1, 50, -1);

        // Halt and timeout on the same cycle: counts as a halt.
        for (int i = 0; i <= 97; i++) trace[i] = 32'(4 * i);
        tlen = 98;
        run_case("halt_at_to", -1, -1, -1);

        // 3-cycle hold, change, 4-cycle hold.
        trace[0] = 32'h100; trace[1] = 32'h104;
        trace[2] = 32'h200; trace[3] = 32'h200; trace[4] = 32'h200;
        trace[5] = 32'h300; trace[6] = 32'h300; trace[7] = 32'h300; trace[8] = 32'h300;
        tlen = 9;
        run_case("hold3_hold4", -1, -1, -1);

        // Randomized tables, register contents and pc traces.
        for (int r = 0; r < 6; r++) begin
            randomize_regs();
            for (int i = 0; i < NR; i++) begin
                logic [DW-1:0] v;
                v = regs[i];
                if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
                write_exp(i, v, 1'(($urandom_range(0, 1))));
            end
            gen_trace($urandom_range(2, 12));
            run_case($sformatf("rand%0d", r), -1, -1, -1);
        end

        // Reset on SCAN cycle 10, then a run with an untouched (all don't-care) table.
        gen_trace(4);
        run_case("rst_scan", -1, -1, 10);
        randomize_regs();
        gen_trace(3);
        run_case("after_rst", -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_run_checker.md
PROG_RUN_CHECKER -- requirements
Module: prog_run_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register-file data width.
REQ-002 SHALL have parameter ADDR_W, default 32: program-counter width.
REQ-003 SHALL have parameter NUM_REGS, default 32: registers scanned, range 2..256.
REQ-004 SHALL have parameter IDX_W, default 5: register index width, equal to clog2(NUM_REGS).
REQ-005 SHALL have parameter STABLE_CYCLES, default 4: consecutive unchanged-PC cycles that mean halt.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum RUN cycles before forced scan.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1: begin monitoring; pulse.
REQ-010 SHALL have port pc, input, ADDR_W: CPU program counter.
REQ-011 SHALL have port rf_raddr, output, IDX_W: register-file debug read address.
REQ-012 SHALL have port rf_rdata, input, DATA_W: combinational read data for rf_raddr.
REQ-013 SHALL have port exp_we, input, 1: write one expected-value entry.
REQ-014 SHALL have port exp_idx, input, IDX_W: expected-table index.
REQ-015 SHALL have port exp_value, input, DATA_W: expected register value.
REQ-016 SHALL have port exp_care, input, 1: 1 = compare this register, 0 = ignore it.
REQ-017 SHALL have port busy, output, 1: high in RUN or SCAN.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when the verdict is valid.
REQ-019 SHALL have port pass, output, 1: verdict, held until the next start.
REQ-020 SHALL have port timed_out, output, 1: RUN ended by timeout.
REQ-021 SHALL have port mismatch_cnt, output, IDX_W+1: number of failing registers.
REQ-022 SHALL have port first_bad_idx, output, IDX_W: lowest failing index.
REQ-023 SHALL have port first_bad_data, output, DATA_W: actual value at first_bad_idx.

Function
REQ-024 SHALL implement FSM states IDLE, RUN, SCAN and DONE.
REQ-025 IDLE->RUN on start; IDLE also entered from DONE the cycle after done.
REQ-026 In RUN, SHALL count cycles where pc equals the previous-cycle pc; reset the count on any change; go to SCAN when the count reaches STABLE_CYCLES-1 (STABLE_CYCLES equal pc samples).
REQ-027 In RUN, SHALL increment a cycle counter; on reaching TIMEOUT_CYCLES, SHALL set timed_out and go to SCAN; halt and timeout in the same cycle SHALL count as halt (timed_out=0).
REQ-028 SCAN SHALL drive rf_raddr 0..NUM_REGS-1, one per cycle, and compare rf_rdata at each edge; it SHALL last exactly NUM_REGS cycles.
REQ-029 A register fails when care=1 and rf_rdata != expected; the first failure SHALL latch first_bad_idx and first_bad_data; mismatch_cnt SHALL saturate at its maximum.
REQ-030 After the final compare, SHALL enter DONE and pulse done for one cycle, with pass = (mismatch_cnt==0) AND NOT timed_out.
REQ-031 Expected table: NUM_REGS entries of {care, value}; exp_we SHALL write it only in IDLE or DONE and SHALL be ignored in RUN and SCAN.
REQ-032 start SHALL be ignored while busy; start in DONE SHALL be honoured as IDLE->RUN on the next cycle.
REQ-033 On start, SHALL clear mismatch_cnt, first_bad_*, timed_out, pass, and both counters; the expected table SHALL be retained.
REQ-034 rf_raddr SHALL be 0 outside SCAN.

Reset
REQ-035 rst SHALL be sampled only on the rising clk edge and SHALL override all other inputs.
REQ-036 On rst, SHALL set state=IDLE, busy=0, done=0, pass=0, timed_out=0, mismatch_cnt=0, first_bad_idx=0, first_bad_data=0, rf_raddr=0, and all counters to 0.
REQ-037 On rst, SHALL clear every care bit to 0; table values are don't-care.
REQ-038 rst mid-RUN or mid-SCAN SHALL abort with no done pulse.

Structure
REQ-039 FSM state encoding and default parameter constants SHALL live in shared package mips_dbg_pkg.
REQ-040 SHALL contain one sub-module, exp_table: NUM_REGS x (DATA_W+1) storage with a synchronous write port and an asynchronous read port.

Verification
REQ-041 Factorial: expect $v0(2)=0x78, all other care=0; program ends in j-self loop at pc=0x40 -> done within 4+32 cycles of halt, pass=1, mismatch_cnt=0.
REQ-042 Same program with expected $v0=0x77 -> pass=0, mismatch_cnt=1, first_bad_idx=2, first_bad_data=0x78.
REQ-043 TIMEOUT_CYCLES=100, pc increments forever -> timed_out=1 at RUN cycle 100, SCAN still runs, pass=0.
REQ-044 pc holds for 3 cycles, changes, then holds 4 cycles -> no SCAN until the second hold completes.
REQ-045 rst asserted on SCAN cycle 10 -> no done; next cycle all outputs at reset values; every care bit reads 0.
REQ-046 exp_we during RUN writing idx 2 -> table unchanged; start while busy -> counters not cleared.
